sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width; SHALL match the attached 1r1w macro word size.
REQ-002 Parameter ADDR_WIDTH, default 4: macro address width; SRAM depth SHALL be 1<<ADDR_WIDTH (16).
REQ-003 clk  in  1  sole clock; SHALL also drive macro clk0 and clk1 externally.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1 / in_ready  out  1 / in_data  in  DATA_WIDTH: push handshake.
REQ-006 out_valid  out  1 / out_ready  in  1 / out_data  out  DATA_WIDTH: pop handshake.
REQ-007 csb0  out  1 / addr0  out  ADDR_WIDTH / din0  out  DATA_WIDTH: macro write port, csb0 active-low.
REQ-008 csb1  out  1 / addr1  out  ADDR_WIDTH / dout1  in  DATA_WIDTH: macro read port, csb1 active-low.
REQ-009 level  out  ADDR_WIDTH+2: total entries held (SRAM + in-flight read + output buffer), range 0..DEPTH+2.

Function
REQ-010 Transfer occurs on a rising clk edge when valid and ready are both 1; payload is held stable by the sender while valid=1 and ready=0.
REQ-011 in_ready SHALL be 1 iff sram_cnt < DEPTH; it depends on registered state only.
REQ-012 On push, csb0=0, addr0=wr_ptr, din0=in_data, all driven combinationally in the same cycle; otherwise csb0=1, addr0/din0 hold last value.
REQ-013 wr_ptr and rd_ptr SHALL wrap modulo DEPTH; sram_cnt SHALL be ADDR_WIDTH+1 bits, range 0..DEPTH.
REQ-014 Read issue: csb1=0, addr1=rd_ptr, iff sram_cnt>0 and (ob_cnt + rd_inflight - pop) < 2; else csb1=1.
REQ-015 rd_inflight SHALL be set on the edge where csb1=0 and cleared on the following edge, where dout1 SHALL be captured into the output buffer.
REQ-016 Read latency: issue at edge E, data captured at E+1; dout1 SHALL never be sampled at any other edge (macro drives X after hold).
REQ-017 Output buffer SHALL be a 2-entry FIFO; out_valid=(ob_cnt>0), out_data=head entry, both registered.
REQ-018 Full throughput: sustained push and pop every cycle SHALL be supported with no bubbles once steady.
REQ-019 Push-to-out_valid latency on an empty FIFO SHALL be 2 edges: push at E0, read issued in cycle after E0, out_valid=1 after E2.
REQ-020 Simultaneous push and read issue in one cycle SHALL both proceed; sram_cnt unchanged.
REQ-021 Write and read of the same address in one cycle SHALL never occur; this holds because reads require sram_cnt>0 and writes require sram_cnt<DEPTH.
REQ-022 Pop with ob_cnt=2 and a capture in the same edge SHALL leave ob_cnt=2 with order preserved.
REQ-023 level SHALL update on every edge as sram_cnt + rd_inflight + ob_cnt.

Reset
REQ-024 While rst_n=0: wr_ptr=rd_ptr=0, sram_cnt=0, rd_inflight=0, ob_cnt=0, out_valid=0, in_ready=0, csb0=csb1=1, level=0.
REQ-025 Reset asserted mid-operation SHALL discard all contents, including an in-flight read.
REQ-026 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-027 SRAM contents are not cleared; no read of an unwritten address SHALL occur.

Structure
REQ-028 Package sram_fifo_pkg SHALL hold the DATA_WIDTH/ADDR_WIDTH defaults, the DEPTH constant, and the level width.
REQ-029 The output buffer SHALL be a sub-module, sram_fifo_outbuf: 2-entry, with a capture input, pop input, and count output.
REQ-030 The SRAM macro SHALL be instantiated outside this block, alongside it at the same level.

Verification
REQ-031 Push 0xA5 into an empty FIFO with out_ready=0 -> csb0=0 and addr0=0 at the push cycle; csb1=0 and addr1=0 one cycle later; out_valid=1 and out_data=0xA5 two edges after the push; level=1.
REQ-032 Push 18 values 0x00..0x11 with out_ready=0 -> in_ready=0 once sram_cnt=16, level=18, no csb0=0 while full; drain yields 0x00..0x11 in order.
REQ-033 Steady push and pop every cycle for 40 words -> one word out per cycle after 2-edge latency, pointers wrap past 15, level constant.
REQ-034 Random out_ready toggling with 200 random words -> exact order preserved, dout1 never sampled as X, no same-address read/write cycle.
REQ-035 Assert rst_n=0 one cycle after a read issue with level=5 -> all outputs at reset values asynchronously; after release, level=0 and first new push reads back correctly.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared defaults and types for the SRAM-backed FIFO controller.
// The macro itself lives beside the controller; only its geometry is captured here.
package sram_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEPTH          = 1 << DEF_ADDR_WIDTH;
  localparam int unsigned LEVEL_WIDTH    = DEF_ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    OB_IDLE,
    OB_CAP,
    OB_POP,
    OB_SWAP
  } ob_op_e;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry registered output buffer fed by SRAM read captures.
// head is always the oldest entry; valid and head are both flops.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent1;
  logic [1:0]            cnt_nxt;
  ob_op_e                op;

  always_comb begin
    op = OB_IDLE;
    if (cap && pop) begin
      op = OB_SWAP;
    end else if (cap) begin
      op = OB_CAP;
    end else if (pop) begin
      op = OB_POP;
    end

    cnt_nxt = count;
    case (op)
      OB_CAP:  cnt_nxt = count + 2'd1;
      OB_POP:  cnt_nxt = count - 2'd1;
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      ent1  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      count <= cnt_nxt;
      valid <= (cnt_nxt != 2'd0);
      case (op)
        OB_CAP: begin
          if (count == 2'd0) head <= cap_data;
          else               ent1 <= cap_data;
        end
        OB_POP: head <= ent1;
        // With two held, the tail shifts to head and the capture becomes the new tail.
        OB_SWAP: begin
          if (count == 2'd2) begin
            head <= ent1;
            ent1 <= cap_data;
          end else begin
            head <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(cap && !pop && count == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count == 2'd0));

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external 1r1w SRAM macro (write port 0, read port 1).
// Reads are issued ahead into a 2-entry output buffer so push/pop can stream every cycle.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  csb0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int unsigned FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LVL_W      = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   sram_cnt;
  logic [ADDR_WIDTH:0]   sram_cnt_nxt;
  logic                  rd_inflight;
  logic                  in_ready_q;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_q;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic [1:0]            ob_cnt;
  logic [2:0]            ob_demand;

  assign in_ready = in_ready_q;
  assign push     = in_valid & in_ready_q;
  assign pop      = out_valid & out_ready;

  // Entries the buffer must still hold after this edge; a new read needs one free slot.
  assign ob_demand = {1'b0, ob_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue  = (sram_cnt != '0) && (ob_demand < 3'd2);

  assign csb0  = ~push;
  assign addr0 = push ? wr_ptr  : addr0_q;
  assign din0  = push ? in_data : din0_q;
  assign csb1  = ~rd_issue;
  assign addr1 = rd_ptr;

  always_comb begin
    sram_cnt_nxt = sram_cnt;
    case ({push, rd_issue})
      2'b10:   sram_cnt_nxt = sram_cnt + 1'b1;
      2'b01:   sram_cnt_nxt = sram_cnt - 1'b1;
      default: sram_cnt_nxt = sram_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
      in_ready_q  <= 1'b0;
      addr0_q     <= '0;
      din0_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        addr0_q <= wr_ptr;
        din0_q  <= in_data;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      sram_cnt    <= sram_cnt_nxt;
      rd_inflight <= rd_issue;
      in_ready_q  <= (sram_cnt_nxt < CNT_FULL);
    end
  end

  // dout1 is only trusted on the edge right after its read was issued.
  sram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (rd_inflight),
    .cap_data (dout1),
    .pop      (pop),
    .head     (out_data),
    .valid    (out_valid),
    .count    (ob_cnt)
  );

  assign level = LVL_W'(sram_cnt) + LVL_W'(rd_inflight) + LVL_W'(ob_cnt);

  a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(!csb0 && !csb1 && (addr0 == addr1)));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    sram_cnt <= CNT_FULL);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1r1w macro beside it.
// The macro registers read data on the issue edge and drives X when no read is issued.
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       csb0;
  logic [3:0] addr0;
  logic [7:0] din0;
  logic       csb1;
  logic [3:0] addr1;
  logic [7:0] dout1;
  logic [5:0] level;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [16];

  sram_fifo_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .csb0      (csb0),
    .addr0     (addr0),
    .din0      (din0),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!csb0) mem[addr0] <= din0;
    if (!csb1) dout1 <= mem[addr1];
    else       dout1 <= 'x;
  end

  // Continuous protocol monitor, sampled mid low-phase.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (!csb0 && !csb1) begin
        checks++;
        if (addr0 === addr1) begin failures++; $display("FAIL mon_rw_same_addr addr0=%0d addr1=%0d", addr0, addr1); end
      end
      if (!csb0) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mon_write_when_full in_ready=%b", in_ready); end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if ($isunknown(out_data)) begin failures++; $display("FAIL mon_out_data_x got=%h", out_data); end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (csb0 !== 1'b1) begin failures++; $display("FAIL reset_csb0 got=%b exp=1", csb0); end
    checks++; if (csb1 !== 1'b1) begin failures++; $display("FAIL reset_csb1 got=%b exp=1", csb1); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    checks++; if (csb0 !== 1'b0) begin failures++; $display("FAIL single_csb0 got=%b exp=0", csb0); end
    checks++; if (addr0 !== 4'd0) begin failures++; $display("FAIL single_addr0 got=%0d exp=0", addr0); end
    checks++; if (din0 !== 8'hA5) begin failures++; $display("FAIL single_din0 got=%h exp=a5", din0); end
    checks++; if (csb1 !== 1'b1) begin failures++; $display("FAIL single_csb1_early got=%b exp=1", csb1); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (csb0 !== 1'b1) begin failures++; $display("FAIL single_csb0_idle got=%b exp=1", csb0); end
    checks++; if (addr0 !== 4'd0) begin failures++; $display("FAIL single_addr0_hold got=%0d exp=0", addr0); end
    checks++; if (csb1 !== 1'b0) begin failures++; $display("FAIL single_csb1_issue got=%b exp=0", csb1); end
    checks++; if (addr1 !== 4'd0) begin failures++; $display("FAIL single_addr1 got=%0d exp=0", addr1); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_e1 got=%b exp=0", out_valid); end
    checks++; if (level !== 6'd1) begin failures++; $display("FAIL single_level_e1 got=%0d exp=1", level); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_e2 got=%b exp=0", out_valid); end
    checks++; if (csb1 !== 1'b1) begin failures++; $display("FAIL single_csb1_after got=%b exp=1", csb1); end
    checks++; if (level !== 6'd1) begin failures++; $display("FAIL single_level_e2 got=%0d exp=1", level); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_out_data got=%h exp=a5", out_data); end
    checks++; if (level !== 6'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL single_drained_level got=%0d exp=0", level); end
  endtask

  task automatic test_fill();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    out_ready = 1'b0;
    while (sent < 18 && cyc < 100) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(sent);
      #1;
      if (in_ready === 1'b1) sent++;
      cyc++;
    end
    checks++; if (sent != 18) begin failures++; $display("FAIL fill_timeout sent=%0d exp=18", sent); end
    checks++; if (cyc != 18) begin failures++; $display("FAIL fill_cycles got=%0d exp=18", cyc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hEE;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      checks++; if (csb0 !== 1'b1) begin failures++; $display("FAIL full_csb0 got=%b exp=1", csb0); end
      checks++; if (level !== 6'd18) begin failures++; $display("FAIL full_level got=%0d exp=18", level); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (cyc = 0; got < 18 && cyc < 100; cyc++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== 8'(got)) begin failures++; $display("FAIL drain_data got=%h exp=%h", out_data, 8'(got)); end
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    checks++; if (got != 18) begin failures++; $display("FAIL drain_count got=%0d exp=18", got); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", level); end
  endtask

  task automatic test_stream();
    int pops = 0;
    logic [3:0] ea;
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      in_valid = (k < 40); in_data = 8'(8'h40 + k); out_ready = 1'b1;
      #1;
      if (k < 40) begin
        ea = 4'(3 + k);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready); end
        checks++; if (csb0 !== 1'b0 || addr0 !== ea) begin failures++; $display("FAIL stream_write k=%0d csb0=%b addr0=%0d exp_addr=%0d", k, csb0, addr0, ea); end
      end
      if (k >= 3 && k <= 40) begin
        checks++; if (level !== 6'd3) begin failures++; $display("FAIL stream_level k=%0d got=%0d exp=3", k, level); end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== 8'(8'h40 + pops) || k != pops + 3) begin failures++; $display("FAIL stream_out k=%0d data=%h exp=%h at_k=%0d", k, out_data, 8'(8'h40 + pops), pops + 3); end
        pops++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (pops != 40) begin failures++; $display("FAIL stream_count got=%0d exp=40", pops); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL stream_end_level got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int sent = 0;
    int got = 0;
    int cyc;
    logic acc = 1'b0;
    @(negedge clk);
    for (cyc = 0; got < 200 && cyc < 6000; cyc++) begin
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(in_data); sent++; acc = 1'b1;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL random_spurious got=%h exp=none", out_data); end
        else begin
          if (out_data !== q[0]) begin failures++; $display("FAIL random_order idx=%0d got=%h exp=%h", got, out_data, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (got != 200) begin failures++; $display("FAIL random_count got=%0d exp=200", got); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL random_end_level got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h15; out_ready = 1'b1;
    #1;
    checks++; if (level !== 6'd5) begin failures++; $display("FAIL mid_level_pre got=%0d exp=5", level); end
    checks++; if (csb1 !== 1'b0) begin failures++; $display("FAIL mid_read_issue got=%b exp=0", csb1); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (level !== 6'd5) begin failures++; $display("FAIL mid_level got=%0d exp=5", level); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL mid_head valid=%b data=%h exp=11", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (csb0 !== 1'b1 || csb1 !== 1'b1) begin failures++; $display("FAIL mid_rst_csb csb0=%b csb1=%b exp=1,1", csb0, csb1); end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || level !== 6'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_release in_ready=%b level=%0d out_valid=%b exp=1,0,0", in_ready, level, out_valid); end
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin failures++; $display("FAIL mid_new_word valid=%b data=%h exp=3c", out_valid, out_data); end
    checks++; if (level !== 6'd1) begin failures++; $display("FAIL mid_new_level got=%0d exp=1", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (level !== 6'd0) begin failures++; $display("FAIL mid_final_level got=%0d exp=0", level); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
